// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 pipeline: opcodes, instruction fields,
// instruction classes, ALU selects and the pipeline register layouts.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Opcode 111110 is unassigned, so it decodes as a harmless no-op
  localparam logic [31:0] NOP_INSTR = 32'hF800_0000;

  // NOP is the zero encoding so a cleared pipeline register is a bubble
  typedef enum logic [2:0] {
    NOP, RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
  } instr_type_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    instr_type_e itype;
    logic [5:0]  op;
    logic [2:0]  alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } id_ex_t;

  typedef struct packed {
    instr_type_e itype;
    logic [4:0]  dst;
    logic [31:0] alu_out;
    logic [31:0] b;
  } ex_mem_t;

  typedef struct packed {
    instr_type_e itype;
    logic [4:0]  dst;
    logic [31:0] alu_out;
    logic [31:0] lmd;
  } mem_wb_t;

  function automatic instr_type_e decode_type(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

  // Loads and stores use the adder for address generation
  function automatic logic [2:0] alu_sel(input logic [5:0] op);
    case (op)
      OP_SUB, OP_SUBI: return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_SLT, OP_SLTI: return ALU_SLT;
      OP_MUL:          return ALU_MUL;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for the EX stage: op select plus two 32-bit operands.
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [2:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // Select the arithmetic/logic result; SLT is a signed compare
  always_comb begin
    y = '0;
    case (alu_op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      ALU_MUL: y = a * b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mips32_pipeline.sv
// Five-stage in-order pipeline with unified word-addressed memory,
// EX-stage forwarding, branch squash and halt sequencing. No stalls:
// load-use and halt spacing are left to software.
module mips32_pipeline
  import mips32_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  // MEM_WORDS is a power of two, so modulo is a plain low-bit slice
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] Mem     [0:MEM_WORDS-1];
  logic [31:0] RegBank [0:31];

  logic [31:0] PC, pc_d;
  logic        HALTED, halted_d;
  logic        TAKEN_BRANCH, taken_branch_d;
  logic        halt_pending_q, halt_pending_d;

  if_id_t  if_id_q,  if_id_d;
  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  logic [AW-1:0] fetch_addr, mem_addr;

  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dst;
  instr_type_e id_type;
  logic [31:0] id_a, id_b, id_imm;

  logic        wb_we;
  logic [31:0] wb_data;
  logic        exm_fwd;

  logic [31:0] ex_a, ex_b, ex_alu_b, ex_alu_out, ex_target;
  logic        ex_taken;
  logic        fetch_block;

  assign halted     = HALTED;
  assign fetch_addr = PC[AW-1:0];
  assign mem_addr   = ex_mem_q.alu_out[AW-1:0];

  // Writeback port: ALU results and loaded words, never to R0
  always_comb begin
    wb_we   = (mem_wb_q.itype inside {RR_ALU, RM_ALU, LOAD}) && (mem_wb_q.dst != 5'd0);
    wb_data = (mem_wb_q.itype == LOAD) ? mem_wb_q.lmd : mem_wb_q.alu_out;
  end

  // Decode and register read, with write-through from the WB stage
  always_comb begin
    id_op   = if_id_q.ir[OP_MSB:OP_LSB];
    id_rs   = if_id_q.ir[RS_MSB:RS_LSB];
    id_rt   = if_id_q.ir[RT_MSB:RT_LSB];
    id_rd   = if_id_q.ir[RD_MSB:RD_LSB];
    id_imm  = {{16{if_id_q.ir[IMM_MSB]}}, if_id_q.ir[IMM_MSB:IMM_LSB]};
    id_type = decode_type(id_op);
    id_dst  = 5'd0;
    case (id_type)
      RR_ALU:       id_dst = id_rd;
      RM_ALU, LOAD: id_dst = id_rt;
      default:      id_dst = 5'd0;
    endcase
    if (id_rs == 5'd0)                      id_a = '0;
    else if (wb_we && mem_wb_q.dst == id_rs) id_a = wb_data;
    else                                     id_a = RegBank[id_rs];
    if (id_rt == 5'd0)                      id_b = '0;
    else if (wb_we && mem_wb_q.dst == id_rt) id_b = wb_data;
    else                                     id_b = RegBank[id_rt];
  end

  // Operand forwarding (EX/MEM ALU result first, then MEM/WB) and branch resolution
  always_comb begin
    exm_fwd = (ex_mem_q.itype inside {RR_ALU, RM_ALU}) && (ex_mem_q.dst != 5'd0);
    if (exm_fwd && ex_mem_q.dst == id_ex_q.rs)    ex_a = ex_mem_q.alu_out;
    else if (wb_we && mem_wb_q.dst == id_ex_q.rs) ex_a = wb_data;
    else                                          ex_a = id_ex_q.a;
    if (exm_fwd && ex_mem_q.dst == id_ex_q.rt)    ex_b = ex_mem_q.alu_out;
    else if (wb_we && mem_wb_q.dst == id_ex_q.rt) ex_b = wb_data;
    else                                          ex_b = id_ex_q.b;
    ex_alu_b  = (id_ex_q.itype == RR_ALU) ? ex_b : id_ex_q.imm;
    ex_target = id_ex_q.npc + id_ex_q.imm;
    ex_taken  = (id_ex_q.itype == BRANCH) &&
                (((id_ex_q.op == OP_BNEQZ) && (ex_a != 32'd0)) ||
                 ((id_ex_q.op == OP_BEQZ)  && (ex_a == 32'd0)));
    fetch_block = halt_pending_q || ((id_type == HALT) && !ex_taken);
  end

  mips32_alu u_alu (
    .alu_op (id_ex_q.alu_op),
    .a      (ex_a),
    .b      (ex_alu_b),
    .y      (ex_alu_out)
  );

  // Next-state for PC, status flags and all pipeline registers; frozen once halted
  always_comb begin
    pc_d           = PC;
    halted_d       = HALTED;
    taken_branch_d = TAKEN_BRANCH;
    halt_pending_d = halt_pending_q;
    if_id_d        = if_id_q;
    id_ex_d        = id_ex_q;
    ex_mem_d       = ex_mem_q;
    mem_wb_d       = mem_wb_q;
    if (!HALTED) begin
      if (ex_taken) begin
        pc_d        = ex_target;
        if_id_d.ir  = NOP_INSTR;
        if_id_d.npc = '0;
      end else if (fetch_block) begin
        if_id_d.ir  = NOP_INSTR;
        if_id_d.npc = '0;
      end else begin
        if_id_d.ir  = Mem[fetch_addr];
        if_id_d.npc = PC + 32'd1;
        pc_d        = PC + 32'd1;
      end
      halt_pending_d = fetch_block;
      taken_branch_d = ex_taken;

      if (ex_taken) begin
        id_ex_d = '0;
      end else begin
        id_ex_d.itype  = id_type;
        id_ex_d.op     = id_op;
        id_ex_d.alu_op = alu_sel(id_op);
        id_ex_d.rs     = id_rs;
        id_ex_d.rt     = id_rt;
        id_ex_d.dst    = id_dst;
        id_ex_d.a      = id_a;
        id_ex_d.b      = id_b;
        id_ex_d.imm    = id_imm;
        id_ex_d.npc    = if_id_q.npc;
      end

      ex_mem_d.itype   = id_ex_q.itype;
      ex_mem_d.dst     = id_ex_q.dst;
      ex_mem_d.alu_out = ex_alu_out;
      ex_mem_d.b       = ex_b;

      mem_wb_d.itype   = ex_mem_q.itype;
      mem_wb_d.dst     = ex_mem_q.dst;
      mem_wb_d.alu_out = ex_mem_q.alu_out;
      mem_wb_d.lmd     = Mem[mem_addr];

      halted_d = (mem_wb_q.itype == HALT);
    end
  end

  // Pipeline and status registers; reset loads bubbles and RESET_PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC             <= RESET_PC;
      HALTED         <= 1'b0;
      TAKEN_BRANCH   <= 1'b0;
      halt_pending_q <= 1'b0;
      if_id_q        <= {NOP_INSTR, 32'd0};
      id_ex_q        <= '0;
      ex_mem_q       <= '0;
      mem_wb_q       <= '0;
    end else begin
      PC             <= pc_d;
      HALTED         <= halted_d;
      TAKEN_BRANCH   <= taken_branch_d;
      halt_pending_q <= halt_pending_d;
      if_id_q        <= if_id_d;
      id_ex_q        <= id_ex_d;
      ex_mem_q       <= ex_mem_d;
      mem_wb_q       <= mem_wb_d;
    end
  end

  // Store port in MEM; contents survive reset
  always_ff @(posedge clk) begin
    if (!HALTED && ex_mem_q.itype == STORE) begin
      Mem[mem_addr] <= ex_mem_q.b;
    end
  end

  // Register file write in WB; contents survive reset
  always_ff @(posedge clk) begin
    if (!HALTED && wb_we) begin
      RegBank[mem_wb_q.dst] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mips32_pipeline.sv
// Directed self-checking bench for mips32_pipeline: programs are preloaded
// through hierarchy, run to HLT, then registers/memory are compared against
// a table of hand-computed results.
module tb_mips32_pipeline;

  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] SUB   = 6'b000001;
  localparam logic [5:0] OR_   = 6'b000011;
  localparam logic [5:0] SLT   = 6'b000100;
  localparam logic [5:0] MUL   = 6'b000101;
  localparam logic [5:0] LW    = 6'b001000;
  localparam logic [5:0] SW    = 6'b001001;
  localparam logic [5:0] ADDI  = 6'b001010;
  localparam logic [5:0] SUBI  = 6'b001011;
  localparam logic [5:0] SLTI  = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [31:0] HLT  = 32'hFC00_0000;

  typedef struct packed {
    logic [3:0]  test_id;
    logic        is_mem;
    logic [9:0]  idx;
    logic [31:0] exp;
  } check_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  int passed = 0;
  int total  = 0;
  check_t checks [0:39];
  int n_checks = 0;
  int taken_cnt;

  mips32_pipeline #(.MEM_WORDS(1024), .RESET_PC(32'd0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  function automatic logic [31:0] encR(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, act, act, exp, exp);
  endtask

  task automatic addCheck(input int t, input bit m, input int idx, input logic [31:0] e);
    checks[n_checks] = {4'(t), m, 10'(idx), e};
    n_checks++;
  endtask

  // Hold the core in reset and give memory/registers a known image
  task automatic resetCore();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'h0;
    for (int r = 0; r < 32; r++) dut.RegBank[r] = 32'(r);
    @(negedge clk);
  endtask

  // Release reset and run to HLT within a cycle budget, counting taken-branch cycles
  task automatic applyStimulus(input int t, input int budget, output int taken);
    int cyc;
    cyc   = 0;
    taken = 0;
    rst_n = 1'b1;
    while (halted !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (dut.TAKEN_BRANCH === 1'b1) taken++;
    end
    checkOutput($sformatf("t%0d halted within %0d cycles", t, budget), {31'b0, halted}, 32'd1);
  endtask

  task automatic checkTable(input int t);
    for (int i = 0; i < n_checks; i++) begin
      if (checks[i].test_id == 4'(t)) begin
        if (checks[i].is_mem)
          checkOutput($sformatf("t%0d Mem[%0d]", t, checks[i].idx),
                      dut.Mem[checks[i].idx], checks[i].exp);
        else
          checkOutput($sformatf("t%0d R%0d", t, checks[i].idx),
                      dut.RegBank[checks[i].idx[4:0]], checks[i].exp);
      end
    end
  endtask

  task automatic loadForwardProg();
    dut.Mem[0] = encI(ADDI, 5'd0, 5'd1, 16'd10);
    dut.Mem[1] = encI(ADDI, 5'd0, 5'd2, 16'd20);
    dut.Mem[2] = encR(ADD, 5'd1, 5'd2, 5'd3);
    dut.Mem[3] = encR(ADD, 5'd3, 5'd1, 5'd4);
    dut.Mem[4] = encR(SUB, 5'd4, 5'd2, 5'd5);
    dut.Mem[5] = HLT;
  endtask

  initial begin
    // Expected results per test: {test, is_mem, index, value}
    addCheck(1, 0, 1, 32'd120);  addCheck(1, 0, 2, 32'd130);
    addCheck(1, 0, 3, 32'd3);    addCheck(1, 1, 121, 32'd130);
    addCheck(1, 1, 120, 32'd85);
    addCheck(2, 0, 3, 32'd30);   addCheck(2, 0, 4, 32'd40);
    addCheck(2, 0, 5, 32'd20);   addCheck(2, 0, 6, 32'd6);
    addCheck(3, 1, 198, 32'd5040); addCheck(3, 0, 2, 32'd5040);
    addCheck(3, 0, 3, 32'd0);    addCheck(3, 0, 11, 32'd12);
    addCheck(3, 0, 12, 32'd13);  addCheck(3, 0, 20, 32'd20);
    addCheck(4, 0, 6, 32'd6);    addCheck(4, 0, 0, 32'd0);
    addCheck(5, 0, 1, 32'd10);   addCheck(5, 0, 3, 32'd30);
    addCheck(5, 0, 4, 32'd40);   addCheck(5, 0, 5, 32'd20);
    addCheck(6, 0, 0, 32'd0);    addCheck(6, 0, 7, 32'd1);
    addCheck(6, 0, 8, 32'd1);    addCheck(6, 0, 9, 32'd0);
    addCheck(6, 0, 13, 32'd0);

    resetCore();
    checkOutput("reset PC", dut.PC, 32'd0);
    checkOutput("reset halted", {31'b0, halted}, 32'd0);

    // Test 1: load / add / store with one dummy between dependents
    resetCore();
    dut.Mem[0] = encI(ADDI, 5'd0, 5'd1, 16'd120);
    dut.Mem[1] = encR(OR_, 5'd3, 5'd3, 5'd3);
    dut.Mem[2] = encI(LW, 5'd1, 5'd2, 16'd0);
    dut.Mem[3] = encR(OR_, 5'd3, 5'd3, 5'd3);
    dut.Mem[4] = encI(ADDI, 5'd2, 5'd2, 16'd45);
    dut.Mem[5] = encR(OR_, 5'd3, 5'd3, 5'd3);
    dut.Mem[6] = encI(SW, 5'd1, 5'd2, 16'd1);
    dut.Mem[7] = HLT;
    dut.Mem[120] = 32'd85;
    applyStimulus(1, 20, taken_cnt);
    checkTable(1);

    // Test 2: back-to-back forwarding
    resetCore();
    loadForwardProg();
    applyStimulus(2, 30, taken_cnt);
    checkTable(2);

    // Test 3: factorial loop; R11/R12 increment only when not squashed
    resetCore();
    dut.Mem[0]  = encI(ADDI, 5'd0, 5'd10, 16'd200);
    dut.Mem[1]  = encI(ADDI, 5'd0, 5'd2, 16'd1);
    dut.Mem[2]  = encI(LW, 5'd10, 5'd3, 16'd0);
    dut.Mem[3]  = encR(OR_, 5'd20, 5'd20, 5'd20);
    dut.Mem[4]  = encR(MUL, 5'd2, 5'd3, 5'd2);
    dut.Mem[5]  = encI(SUBI, 5'd3, 5'd3, 16'd1);
    dut.Mem[6]  = encI(BNEQZ, 5'd3, 5'd0, 16'hFFFD);
    dut.Mem[7]  = encI(ADDI, 5'd11, 5'd11, 16'd1);
    dut.Mem[8]  = encI(ADDI, 5'd12, 5'd12, 16'd1);
    dut.Mem[9]  = encI(SW, 5'd10, 5'd2, 16'hFFFE);
    dut.Mem[10] = HLT;
    dut.Mem[200] = 32'd7;
    applyStimulus(3, 200, taken_cnt);
    checkTable(3);
    checkOutput("t3 taken-branch cycles", 32'(taken_cnt), 32'd6);

    // Test 4: HLT squashes the next instruction and freezes the core
    resetCore();
    dut.Mem[0] = HLT;
    dut.Mem[1] = encI(ADDI, 5'd0, 5'd6, 16'd99);
    applyStimulus(4, 20, taken_cnt);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t4 halted hold cycle %0d", c), {31'b0, halted}, 32'd1);
    end
    checkOutput("t4 PC frozen", dut.PC, 32'd1);
    checkTable(4);

    // Test 5: async reset mid-run, then rerun to identical results
    resetCore();
    loadForwardProg();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5 async reset PC", dut.PC, 32'd0);
    checkOutput("t5 async reset halted", {31'b0, halted}, 32'd0);
    @(negedge clk);
    applyStimulus(5, 30, taken_cnt);
    checkTable(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5 reset clears halted", {31'b0, halted}, 32'd0);

    // Test 6: R0 is hardwired, signed SLT/SLTI
    resetCore();
    dut.RegBank[1] = 32'hFFFF_FFFF;
    dut.RegBank[2] = 32'd2;
    dut.Mem[0] = encI(ADDI, 5'd0, 5'd0, 16'd5);
    dut.Mem[1] = encR(SLT, 5'd1, 5'd0, 5'd7);
    dut.Mem[2] = encI(SLTI, 5'd2, 5'd8, 16'd3);
    dut.Mem[3] = encR(SLT, 5'd2, 5'd1, 5'd9);
    dut.Mem[4] = encI(SLTI, 5'd1, 5'd13, 16'hFFFB);
    dut.Mem[5] = HLT;
    applyStimulus(6, 20, taken_cnt);
    checkTable(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
